fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer sitting between the core's decode stage and inst_mem.
- Owns the program counter and drives inst_mem.read_adr.
- Captures each returned instruction into a one-entry output buffer with a valid/ready handshake toward decode.
- Handles branch/jump redirects with flush, halts on EBREAK, and traps out-of-range or misaligned fetches.

Parameters:
- width, 32, instruction width (matches inst_mem width)
- depth, 80, number of inst_mem entries
- adr_in, 64, PC / read_adr width
- RESET_PC, 0, byte address loaded into PC at reset

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; leaves IDLE and begins fetching
- read_adr  out  adr_in  word index to inst_mem, equal to pc >> 2 (zero-extended)
- instruction  in  width  inst_mem read data; asynchronous read of read_adr, valid in the same cycle
- inst_out  out  width  buffered instruction to decode
- pc_out  out  adr_in  byte address of inst_out
- inst_valid  out  1  inst_out/pc_out hold a valid instruction
- inst_ready  in  1  decode accepts the buffer this cycle
- redirect_en  in  1  branch/jump taken; load redirect_adr
- redirect_adr  in  adr_in  byte target address
- halted  out  1  controller in HALT
- fault  out  1  sticky trap indicator
- fault_adr  out  adr_in  byte address that caused the fault
- fetch_count  out  32  number of completed inst_valid&&inst_ready handshakes

Behaviour:
- Clock and reset: all state updates on posedge clk. rst is sampled synchronously and has priority over everything.
- Reset values:
  - state=IDLE, pc=RESET_PC
  - inst_out=0, pc_out=0, inst_valid=0
  - halted=0, fault=0, fault_adr=0, fetch_count=0
  - read_adr always reflects pc[adr_in-1:2] combinationally.
- States: IDLE, RUN, HALT, FAULT.
- IDLE:
  - No capture.
  - start=1 -> RUN next cycle.
  - redirect_en in IDLE loads pc with redirect_adr (alignment checked as below); state stays IDLE.
- RUN: a fetch slot exists when inst_valid==0 || inst_ready==1.
  - In a fetch slot with (pc>>2) < depth:
    - inst_out<=instruction, pc_out<=pc, inst_valid<=1, pc<=pc+4.
    - Latency: instruction at pc is presented on inst_out one cycle after the slot.
  - In a fetch slot with (pc>>2) >= depth:
    - No capture; inst_valid<=0.
    - fault<=1, fault_adr<=pc, state->FAULT.
  - No slot (inst_valid && !inst_ready): pc, inst_out, pc_out and inst_valid hold. Stall of arbitrary length; no instruction lost or duplicated.
  - Sustained inst_ready=1 gives one instruction per cycle.
- Handshake: fetch_count increments in every cycle with inst_valid && inst_ready, in any state. It wraps at 2^32.
- Redirect (RUN or HALT, rst deasserted), priority over fetch:
  - pc<=redirect_adr, inst_valid<=0 (the buffered instruction is flushed, even if inst_ready=1 in that cycle; that handshake still counts).
  - No capture in the redirect cycle; first instruction from the target appears on inst_out two cycles after redirect_en.
  - HALT -> RUN.
  - redirect_adr[1:0]!=0: fault<=1, fault_adr<=redirect_adr, inst_valid<=0, state->FAULT; pc unchanged.
- HALT entry:
  - When the captured instruction equals 32'h00100073 (EBREAK), it is delivered normally, but state->HALT in the same edge and halted=1.
  - No further fetch slots; pc stays at EBREAK address+4.
  - The pending EBREAK remains on the output until accepted.
  - Exit only via redirect_en or rst.
- FAULT:
  - Terminal; fault and fault_adr sticky.
  - start and redirect_en ignored; inst_valid stays 0.
  - Exit only via rst.
- Simultaneous events:
  - rst > redirect_en > fetch.
  - start in RUN/HALT/FAULT is ignored.
  - redirect_en and start together in IDLE: pc loads and state->RUN.
- Reset mid-operation: returns to IDLE with all reset values next edge; in-flight instruction discarded.
- PC arithmetic: pc+4 is modulo 2^adr_in. The bound check uses the full pc>>2 comparison against depth (no truncation).

Test Plan:
- Preload memory[0..9]=0..9, RESET_PC=0, start pulse, inst_ready=1 -> inst_out sequence 0,1,...,9 on consecutive cycles with pc_out 0,4,...,36; fetch_count=10 after the 10th handshake.
- After 3 instructions, hold inst_ready=0 for 5 cycles -> inst_out=2, pc_out=8 held, read_adr=3 held; on release the sequence continues 3,4 with no gap or duplicate.
- redirect_en with redirect_adr=0x20 while inst_out=4 is valid -> inst_valid=0 next cycle, then inst_out=memory[8], pc_out=0x20.
- memory[5]=32'h00100073 -> EBREAK delivered with pc_out=20, halted=1, no further captures; redirect_adr=0 -> halted=0, fetch resumes at memory[0].
- Run to pc=320 (depth 80) -> fault=1, fault_adr=320, inst_valid=0; start/redirect ignored; rst -> all outputs 0, state IDLE.
- redirect_adr=0x22 in RUN -> fault=1, fault_adr=0x22; rst asserted mid-stall with inst_valid=1 -> next cycle inst_valid=0, fetch_count=0.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads inst_mem asynchronously,
// and presents one buffered instruction at a time to decode.
//
// Handshake toward decode: inst_out/pc_out are meaningful only while
// inst_valid=1 and then stay stable until the cycle where inst_valid and
// inst_ready are both 1 at a rising edge. That cycle completes one transfer.
// A redirect flushes the buffer, but a transfer in that same cycle still
// counts as completed.
module fetch_ctrl #(
   parameter int width = 32,
   parameter int depth = 80,
   parameter int adr_in = 64,
   parameter logic [adr_in-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [adr_in-1:0] read_adr,
   input  logic [width-1:0]  instruction,
   output logic [width-1:0]  inst_out,
   output logic [adr_in-1:0] pc_out,
   output logic              inst_valid,
   input  logic              inst_ready,
   input  logic              redirect_en,
   input  logic [adr_in-1:0] redirect_adr,
   output logic              halted,
   output logic              fault,
   output logic [adr_in-1:0] fault_adr,
   output logic [31:0]       fetch_count,
   output logic [1:0]        state_dbg
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      HALT  = 2'd2,
      FAULT = 2'd3
   } state_t;

   localparam logic [width-1:0]  EBREAK  = width'(32'h0010_0073);
   localparam logic [adr_in-3:0] DEPTH_W = (adr_in-2)'(depth);

   state_t            state;
   logic [adr_in-1:0] pc;
   logic [adr_in-3:0] word_idx;
   logic              in_range;
   logic              slot;
   logic              handshake;
   logic              redirect_misaligned;

   // Word index of the PC; the bound check uses the full index, no truncation.
   assign word_idx            = pc[adr_in-1:2];
   assign read_adr            = {2'b00, word_idx};
   assign in_range            = (word_idx < DEPTH_W);
   assign slot                = !inst_valid || inst_ready;
   assign handshake           = inst_valid && inst_ready;
   assign redirect_misaligned = (redirect_adr[1:0] != 2'b00);
   assign state_dbg           = state;

   // Controller state, PC, output buffer, trap and handshake counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         inst_out    <= '0;
         pc_out      <= '0;
         inst_valid  <= 1'b0;
         halted      <= 1'b0;
         fault       <= 1'b0;
         fault_adr   <= '0;
         fetch_count <= '0;
      end else begin
         // Transfers are counted in every state, including the redirect cycle.
         if (handshake) begin
            fetch_count <= fetch_count + 32'd1;
         end

         case (state)
            IDLE: begin
               if (redirect_en && redirect_misaligned) begin
                  fault      <= 1'b1;
                  fault_adr  <= redirect_adr;
                  inst_valid <= 1'b0;
                  state      <= FAULT;
               end else begin
                  if (redirect_en) begin
                     pc <= redirect_adr;
                  end
                  if (start) begin
                     state <= RUN;
                  end
               end
            end

            RUN: begin
               if (redirect_en) begin
                  // Redirect beats fetch: flush the buffer, no capture this cycle.
                  inst_valid <= 1'b0;
                  if (redirect_misaligned) begin
                     fault     <= 1'b1;
                     fault_adr <= redirect_adr;
                     state     <= FAULT;
                  end else begin
                     pc <= redirect_adr;
                  end
               end else if (slot) begin
                  if (in_range) begin
                     inst_out   <= instruction;
                     pc_out     <= pc;
                     inst_valid <= 1'b1;
                     pc         <= pc + adr_in'(4);
                     // EBREAK is still delivered; fetching stops behind it.
                     if (instruction == EBREAK) begin
                        halted <= 1'b1;
                        state  <= HALT;
                     end
                  end else begin
                     inst_valid <= 1'b0;
                     fault      <= 1'b1;
                     fault_adr  <= pc;
                     state      <= FAULT;
                  end
               end
            end

            HALT: begin
               if (redirect_en) begin
                  inst_valid <= 1'b0;
                  halted     <= 1'b0;
                  if (redirect_misaligned) begin
                     fault     <= 1'b1;
                     fault_adr <= redirect_adr;
                     state     <= FAULT;
                  end else begin
                     pc    <= redirect_adr;
                     state <= RUN;
                  end
               end else if (handshake) begin
                  // Pending EBREAK accepted; nothing follows it.
                  inst_valid <= 1'b0;
               end
            end

            FAULT: begin
               inst_valid <= 1'b0;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with an 80-word instruction memory model.
module tb_fetch_ctrl;

   logic        clk;
   logic        rst;
   logic        start;
   logic [63:0] read_adr;
   logic [31:0] instruction;
   logic [31:0] inst_out;
   logic [63:0] pc_out;
   logic        inst_valid;
   logic        inst_ready;
   logic        redirect_en;
   logic [63:0] redirect_adr;
   logic        halted;
   logic        fault;
   logic [63:0] fault_adr;
   logic [31:0] fetch_count;
   logic [1:0]  state_dbg;

   logic [31:0] mem [0:79];
   int n_cmp;
   int n_err;

   fetch_ctrl #(.width(32), .depth(80), .adr_in(64), .RESET_PC(64'd0)) dut (
      .clk(clk), .rst(rst), .start(start), .read_adr(read_adr),
      .instruction(instruction), .inst_out(inst_out), .pc_out(pc_out),
      .inst_valid(inst_valid), .inst_ready(inst_ready),
      .redirect_en(redirect_en), .redirect_adr(redirect_adr),
      .halted(halted), .fault(fault), .fault_adr(fault_adr),
      .fetch_count(fetch_count), .state_dbg(state_dbg)
   );

   // Asynchronous-read memory model; out-of-range reads return zero.
   assign instruction = (read_adr < 64'd80) ? mem[read_adr[6:0]] : 32'h0;

   // Clock generation.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; redirect_en = 1'b0; inst_ready = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      redirect_adr = 64'd0;
      do_reset();
      n_cmp++; if (state_dbg !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
      n_cmp++; if (inst_out !== 32'd0) begin n_err++; $display("FAIL reset_inst_out: got %0h expected 0", inst_out); end
      n_cmp++; if (pc_out !== 64'd0) begin n_err++; $display("FAIL reset_pc_out: got %0h expected 0", pc_out); end
      n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL reset_inst_valid: got %0b expected 0", inst_valid); end
      n_cmp++; if ({halted, fault} !== 2'b00) begin n_err++; $display("FAIL reset_flags: got %0b expected 00", {halted, fault}); end
      n_cmp++; if (fault_adr !== 64'd0) begin n_err++; $display("FAIL reset_fault_adr: got %0h expected 0", fault_adr); end
      n_cmp++; if (fetch_count !== 32'd0) begin n_err++; $display("FAIL reset_fetch_count: got %0d expected 0", fetch_count); end
      n_cmp++; if (read_adr !== 64'd0) begin n_err++; $display("FAIL reset_read_adr: got %0h expected 0", read_adr); end
   endtask

   task automatic test_sequence();
      do_reset();
      start = 1'b1;
      tick();
      start = 1'b0;
      n_cmp++; if (state_dbg !== 2'd1) begin n_err++; $display("FAIL seq_run: got %0d expected 1", state_dbg); end
      n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL seq_first_valid: got %0b expected 0", inst_valid); end
      for (int k = 0; k < 10; k++) begin
         tick();
         n_cmp++; if (inst_out !== 32'(k) || pc_out !== 64'(4*k) || inst_valid !== 1'b1) begin
            n_err++; $display("FAIL seq_word%0d: got inst %0h pc %0h v %0b expected inst %0h pc %0h v 1", k, inst_out, pc_out, inst_valid, k, 4*k);
         end
      end
      tick();
      n_cmp++; if (fetch_count !== 32'd10) begin n_err++; $display("FAIL seq_count: got %0d expected 10", fetch_count); end
   endtask

   task automatic test_stall();
      do_reset();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      inst_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         n_cmp++; if (inst_out !== 32'd2 || pc_out !== 64'd8 || read_adr !== 64'd3 || inst_valid !== 1'b1) begin
            n_err++; $display("FAIL stall_hold%0d: got inst %0h pc %0h radr %0h v %0b expected 2 8 3 1", k, inst_out, pc_out, read_adr, inst_valid);
         end
      end
      n_cmp++; if (fetch_count !== 32'd2) begin n_err++; $display("FAIL stall_count: got %0d expected 2", fetch_count); end
      inst_ready = 1'b1;
      tick();
      n_cmp++; if (inst_out !== 32'd3 || pc_out !== 64'd12) begin n_err++; $display("FAIL stall_release3: got %0h/%0h expected 3/c", inst_out, pc_out); end
      tick();
      n_cmp++; if (inst_out !== 32'd4 || fetch_count !== 32'd4) begin n_err++; $display("FAIL stall_release4: got %0h cnt %0d expected 4 cnt 4", inst_out, fetch_count); end
   endtask

   // Continues from test_stall with inst_out=4 valid.
   task automatic test_redirect();
      redirect_en = 1'b1; redirect_adr = 64'h20;
      tick();
      redirect_en = 1'b0;
      n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL redir_flush: got %0b expected 0", inst_valid); end
      n_cmp++; if (fetch_count !== 32'd5) begin n_err++; $display("FAIL redir_count: got %0d expected 5", fetch_count); end
      n_cmp++; if (read_adr !== 64'd8) begin n_err++; $display("FAIL redir_read_adr: got %0h expected 8", read_adr); end
      tick();
      n_cmp++; if (inst_out !== 32'd8 || pc_out !== 64'h20 || inst_valid !== 1'b1) begin
         n_err++; $display("FAIL redir_target: got %0h/%0h v %0b expected 8/20 v 1", inst_out, pc_out, inst_valid);
      end
   endtask

   task automatic test_idle_redirect();
      do_reset();
      start = 1'b1; redirect_en = 1'b1; redirect_adr = 64'h10;
      tick();
      start = 1'b0; redirect_en = 1'b0;
      n_cmp++; if (state_dbg !== 2'd1 || read_adr !== 64'd4) begin n_err++; $display("FAIL idle_redir: got st %0d radr %0h expected 1 4", state_dbg, read_adr); end
      tick();
      n_cmp++; if (inst_out !== 32'd4 || pc_out !== 64'h10) begin n_err++; $display("FAIL idle_redir_fetch: got %0h/%0h expected 4/10", inst_out, pc_out); end
   endtask

   task automatic test_halt();
      mem[5] = 32'h0010_0073;
      do_reset();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      tick();
      n_cmp++; if (inst_out !== 32'h0010_0073 || pc_out !== 64'd20 || inst_valid !== 1'b1) begin
         n_err++; $display("FAIL halt_ebreak: got %0h/%0h v %0b expected 100073/14 v 1", inst_out, pc_out, inst_valid);
      end
      n_cmp++; if (halted !== 1'b1 || state_dbg !== 2'd2) begin n_err++; $display("FAIL halt_state: got h %0b st %0d expected 1 2", halted, state_dbg); end
      inst_ready = 1'b0;
      tick(); tick();
      n_cmp++; if (inst_valid !== 1'b1 || inst_out !== 32'h0010_0073 || read_adr !== 64'd6) begin
         n_err++; $display("FAIL halt_hold: got v %0b %0h radr %0h expected 1 100073 6", inst_valid, inst_out, read_adr);
      end
      inst_ready = 1'b1;
      tick(); tick();
      n_cmp++; if (inst_valid !== 1'b0 || read_adr !== 64'd6 || halted !== 1'b1) begin
         n_err++; $display("FAIL halt_no_fetch: got v %0b radr %0h h %0b expected 0 6 1", inst_valid, read_adr, halted);
      end
      n_cmp++; if (fetch_count !== 32'd6) begin n_err++; $display("FAIL halt_count: got %0d expected 6", fetch_count); end
      redirect_en = 1'b1; redirect_adr = 64'd0;
      tick();
      redirect_en = 1'b0;
      n_cmp++; if (halted !== 1'b0 || state_dbg !== 2'd1 || inst_valid !== 1'b0) begin
         n_err++; $display("FAIL halt_exit: got h %0b st %0d v %0b expected 0 1 0", halted, state_dbg, inst_valid);
      end
      tick();
      n_cmp++; if (inst_out !== 32'd0 || pc_out !== 64'd0 || inst_valid !== 1'b1) begin
         n_err++; $display("FAIL halt_resume: got %0h/%0h v %0b expected 0/0 v 1", inst_out, pc_out, inst_valid);
      end
      mem[5] = 32'd5;
   endtask

   task automatic test_fault_range();
      do_reset();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 80; k++) tick();
      n_cmp++; if (inst_out !== 32'd79 || pc_out !== 64'd316 || fetch_count !== 32'd79) begin
         n_err++; $display("FAIL range_last: got %0d/%0d cnt %0d expected 79/316 cnt 79", inst_out, pc_out, fetch_count);
      end
      tick();
      n_cmp++; if (fault !== 1'b1 || fault_adr !== 64'd320 || inst_valid !== 1'b0 || state_dbg !== 2'd3) begin
         n_err++; $display("FAIL range_fault: got f %0b adr %0d v %0b st %0d expected 1 320 0 3", fault, fault_adr, inst_valid, state_dbg);
      end
      n_cmp++; if (fetch_count !== 32'd80) begin n_err++; $display("FAIL range_count: got %0d expected 80", fetch_count); end
      start = 1'b1; redirect_en = 1'b1; redirect_adr = 64'd0;
      tick(); tick();
      start = 1'b0; redirect_en = 1'b0;
      n_cmp++; if (state_dbg !== 2'd3 || fault !== 1'b1 || fault_adr !== 64'd320 || read_adr !== 64'd80 || inst_valid !== 1'b0) begin
         n_err++; $display("FAIL range_sticky: got st %0d f %0b adr %0d radr %0d v %0b expected 3 1 320 80 0", state_dbg, fault, fault_adr, read_adr, inst_valid);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_cmp++; if (state_dbg !== 2'd0 || fault !== 1'b0 || fault_adr !== 64'd0 || fetch_count !== 32'd0 || read_adr !== 64'd0 || inst_out !== 32'd0) begin
         n_err++; $display("FAIL range_reset: got st %0d f %0b adr %0d cnt %0d radr %0d inst %0h expected all 0", state_dbg, fault, fault_adr, fetch_count, read_adr, inst_out);
      end
   endtask

   task automatic test_misaligned();
      do_reset();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      redirect_en = 1'b1; redirect_adr = 64'h22;
      tick();
      redirect_en = 1'b0;
      n_cmp++; if (fault !== 1'b1 || fault_adr !== 64'h22 || inst_valid !== 1'b0 || state_dbg !== 2'd3) begin
         n_err++; $display("FAIL misalign_fault: got f %0b adr %0h v %0b st %0d expected 1 22 0 3", fault, fault_adr, inst_valid, state_dbg);
      end
      n_cmp++; if (read_adr !== 64'd1) begin n_err++; $display("FAIL misalign_pc_kept: got %0h expected 1", read_adr); end
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      inst_ready = 1'b0;
      tick();
      n_cmp++; if (inst_valid !== 1'b1 || inst_out !== 32'd1 || fetch_count !== 32'd1) begin
         n_err++; $display("FAIL midrst_pre: got v %0b %0h cnt %0d expected 1 1 1", inst_valid, inst_out, fetch_count);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_cmp++; if (inst_valid !== 1'b0 || fetch_count !== 32'd0 || state_dbg !== 2'd0 || read_adr !== 64'd0) begin
         n_err++; $display("FAIL midrst_post: got v %0b cnt %0d st %0d radr %0h expected 0 0 0 0", inst_valid, fetch_count, state_dbg, read_adr);
      end
      inst_ready = 1'b1;
   endtask

   // Test sequence and final report.
   initial begin
      n_cmp = 0;
      n_err = 0;
      for (int i = 0; i < 80; i++) mem[i] = 32'(i);
      rst = 1'b1; start = 1'b0; inst_ready = 1'b1; redirect_en = 1'b0; redirect_adr = 64'd0;
      test_reset();
      test_sequence();
      test_stall();
      test_redirect();
      test_idle_redirect();
      test_halt();
      test_fault_range();
      test_misaligned();
      test_reset_mid_stall();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
